// File: rtl/dma_peripheral_responder_pkg.sv
// Shared types for the DMA peripheral responder.
//   PERIPH_STATE_e : responder channel state
//   DMA_DIR_e      : transfer direction as seen from the DMA controller
//   bus_evt_t      : per-cycle decoded bus strobe events (DACK-qualified)
package dma_peripheral_responder_pkg;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_REQ  = 2'd1,
        P_ACK  = 2'd2,
        P_DONE = 2'd3
    } PERIPH_STATE_e;

    typedef enum logic {
        DEV_TO_MEM = 1'b0,
        MEM_TO_DEV = 1'b1
    } DMA_DIR_e;

    typedef struct packed {
        logic ior_low;  // read strobe sampled low with DACK active
        logic ior_end;  // read strobe sampled 0->1 with DACK active
        logic iow_low;  // write strobe sampled low with DACK active
        logic iow_end;  // write strobe sampled 0->1 with DACK active
    } bus_evt_t;

    // Bus value returned when the controller reads an empty TX FIFO.
    localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

endpackage

// File: rtl/dma_peripheral_responder_fifo.sv
// dma_sync_fifo: single-clock FIFO with extra-MSB pointers.
//   clk, rst_n      : clock, async active-low reset (pointers only; contents lost)
//   push/wdata      : write, ignored when full
//   pop/rdata       : read, ignored when empty; rdata is the current head
//   full/empty/count: occupancy
module dma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    // Pointers run mod 2*DEPTH: equal MSBs+LSBs is empty, differing MSB with
    // equal LSBs is full.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dma_peripheral_responder.sv
// dma_peripheral_responder: I/O-device end of one 8237A-style DMA channel.
// Requests service (DREQ) while it has TX data (dir=0) or RX space (dir=1),
// answers DACK + IOR_N/IOW_N strobes on the byte bus and stops on EOP_N.
//   CLK, RESET_N          : clock, async active-low reset
//   DREQ / DACK           : request / acknowledge, polarity set by parameters
//   IOR_N, IOW_N, EOP_N   : active-low bus strobes and end-of-process
//   DB_in / DB_out, DB_oe : byte bus from / to memory side, output enable
//   dir, start            : direction (0 dev->mem) and one-cycle arm pulse
//   src_*                 : local push into TX FIFO
//   snk_*                 : local pop from RX FIFO
//   done/overrun/underrun : sticky status
import dma_peripheral_responder_pkg::*;

module dma_peripheral_responder #(
    parameter int DEPTH       = 8,
    parameter int DREQ_ACT_HI = 1,
    parameter int DACK_ACT_HI = 0,
    parameter int DEMAND_MODE = 0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       EOP_N,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    input  logic       dir,
    input  logic       start,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       snk_valid,
    output logic [7:0] snk_data,
    input  logic       snk_ready,
    output logic       done,
    output logic       overrun,
    output logic       underrun
);
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic            DREQ_INV  = (DREQ_ACT_HI == 0);
    localparam logic            DACK_INV  = (DACK_ACT_HI == 0);
    localparam logic            HOLD_DREQ = (DEMAND_MODE != 0);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);

    PERIPH_STATE_e state;
    DMA_DIR_e      dir_q, dir_nxt;
    bus_evt_t      ev;

    logic          dack, dreq_r, ior_q, iow_q, rd_valid, wr_valid, eop_seen;
    logic          strobe_end, ready_nxt, dreq_hold;
    logic [7:0]    wr_data;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count, tx_cnt_nxt;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [CW-1:0] rx_count, rx_cnt_nxt;

    // Polarity is folded in here; everything inside is active-high.
    assign dack = DACK ^ DACK_INV;
    assign DREQ = dreq_r ^ DREQ_INV;

    // Strobes count only with DACK active and only for the latched direction.
    always_comb begin
        ev         = '0;
        ev.ior_low = dack && !IOR_N && (dir_q == DEV_TO_MEM);
        ev.ior_end = dack &&  IOR_N && !ior_q && (dir_q == DEV_TO_MEM);
        ev.iow_low = dack && !IOW_N && (dir_q == MEM_TO_DEV);
        ev.iow_end = dack &&  IOW_N && !iow_q && (dir_q == MEM_TO_DEV);
    end

    assign strobe_end = ev.ior_end || ev.iow_end;

    // Pop/push only when the previous sample was a qualified low strobe, so a
    // strobe that started before DACK never moves data.
    assign tx_push = src_valid && !tx_full;
    assign tx_pop  = ev.ior_end && rd_valid;
    assign rx_push = ev.iow_end && wr_valid && !rx_full;
    assign rx_pop  = snk_ready && !rx_empty;

    assign src_ready = !tx_full;
    assign snk_valid = !rx_empty;

    // DREQ is registered from post-update occupancy so it never flickers for
    // a cycle after the last byte leaves or the last slot fills.
    assign dir_nxt    = (state == P_IDLE || state == P_DONE) ? DMA_DIR_e'(dir) : dir_q;
    assign tx_cnt_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);
    assign ready_nxt  = (dir_nxt == MEM_TO_DEV) ? (rx_cnt_nxt != FULL_CNT)
                                                : (tx_cnt_nxt != '0);
    assign dreq_hold  = HOLD_DREQ && ready_nxt;

    dma_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (tx_push),
        .wdata (src_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    dma_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (rx_push),
        .wdata (wr_data),
        .pop   (rx_pop),
        .rdata (snk_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Channel FSM; DREQ and done are set per transition from the target state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= P_IDLE;
            dir_q    <= DEV_TO_MEM;
            dreq_r   <= 1'b0;
            done     <= 1'b0;
            eop_seen <= 1'b0;
        end else begin
            dir_q <= dir_nxt;
            case (state)
                P_IDLE, P_DONE: begin
                    if (start) begin
                        state  <= P_REQ;
                        done   <= 1'b0;
                        dreq_r <= ready_nxt;
                    end else begin
                        dreq_r <= 1'b0;
                    end
                end
                P_REQ: begin
                    if (dack) begin
                        state    <= P_ACK;
                        eop_seen <= 1'b0;
                        dreq_r   <= dreq_hold;
                    end else begin
                        dreq_r   <= ready_nxt;
                    end
                end
                P_ACK: begin
                    if (strobe_end) begin
                        eop_seen <= 1'b0;
                        if (eop_seen || !EOP_N) begin
                            state  <= P_DONE;
                            done   <= 1'b1;
                            dreq_r <= 1'b0;
                        end else begin
                            state  <= P_REQ;
                            dreq_r <= ready_nxt;
                        end
                    end else if (!dack) begin
                        // DACK withdrawn mid-cycle: abandon, nothing transferred.
                        state    <= P_REQ;
                        eop_seen <= 1'b0;
                        dreq_r   <= ready_nxt;
                    end else begin
                        if (!EOP_N) eop_seen <= 1'b1;
                        dreq_r <= dreq_hold;
                    end
                end
                default: begin
                    state  <= P_IDLE;
                    dreq_r <= 1'b0;
                end
            endcase
        end
    end

    // Bus datapath: strobe history, read drive, write capture, error flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            rd_valid <= 1'b0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            DB_oe    <= 1'b0;
            DB_out   <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            ior_q    <= IOR_N;
            iow_q    <= IOW_N;
            rd_valid <= ev.ior_low && !tx_empty;
            wr_valid <= ev.iow_low;
            // Enable follows the qualified strobe, so it falls on the pop edge.
            DB_oe    <= ev.ior_low;
            if (ev.ior_low) begin
                DB_out <= tx_empty ? UNDERRUN_BYTE : tx_head;
                if (tx_empty) underrun <= 1'b1;
            end
            if (ev.iow_low) wr_data <= DB_in;
            if (ev.iow_end && wr_valid && rx_full) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_peripheral_responder.sv
module tb_dma_peripheral_responder;
    localparam int DEPTH       = 8;
    localparam int DREQ_ACT_HI = 1;
    localparam int DACK_ACT_HI = 0;
    localparam int DEMAND_MODE = 0;

    logic       CLK = 1'b0;
    logic       RESET_N, DACK, IOR_N, IOW_N, EOP_N, dir, start, src_valid, snk_ready;
    logic [7:0] DB_in, src_data;
    logic       DREQ, DB_oe, src_ready, snk_valid, done, overrun, underrun;
    logic [7:0] DB_out, snk_data;

    dma_peripheral_responder #(
        .DEPTH(DEPTH), .DREQ_ACT_HI(DREQ_ACT_HI),
        .DACK_ACT_HI(DACK_ACT_HI), .DEMAND_MODE(DEMAND_MODE)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
        .dir(dir), .start(start),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .done(done), .overrun(overrun), .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queues plus channel flags, advanced per transaction.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit m_armed, m_done, m_ovr, m_und, m_dir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit dreq_on();
        return (DREQ === (DREQ_ACT_HI != 0));
    endfunction

    function automatic logic dack_level(input bit on);
        return on ? (DACK_ACT_HI != 0) : (DACK_ACT_HI == 0);
    endfunction

    function automatic bit exp_dreq();
        if (!m_armed || m_done) return 1'b0;
        return m_dir ? (rx_q.size() < DEPTH) : (tx_q.size() > 0);
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_done"},     done,     m_done);
        chk({tag, "_overrun"},  overrun,  m_ovr);
        chk({tag, "_underrun"}, underrun, m_und);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!m_armed || m_done) begin
            m_armed = 1'b1;
            m_done  = 1'b0;
            m_dir   = dir;
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        chk("src_ready", src_ready, tx_q.size() < DEPTH);
        src_valid = 1'b1;
        src_data  = d;
        tick();
        src_valid = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        chk("push_dreq", dreq_on(), exp_dreq());
    endtask

    task automatic bus_read(input bit eop);
        logic [7:0] e;
        bit had;
        had   = (tx_q.size() > 0);
        e     = had ? tx_q[0] : 8'hFF;
        DACK  = dack_level(1);
        IOR_N = 1'b0;
        EOP_N = !eop;
        tick();
        chk("rd_oe", DB_oe, 1);
        chk("rd_data", DB_out, e);
        chk("rd_dreq_drop", dreq_on(), 0);
        IOR_N = 1'b1;
        tick();
        if (had) void'(tx_q.pop_front());
        else     m_und = 1'b1;
        if (eop) m_done = 1'b1;
        chk("rd_oe_off", DB_oe, 0);
        chk("rd_dreq", dreq_on(), exp_dreq());
        DACK  = dack_level(0);
        EOP_N = 1'b1;
        tick();
    endtask

    task automatic bus_write(input logic [7:0] d, input bit eop);
        DACK  = dack_level(1);
        IOW_N = 1'b0;
        EOP_N = !eop;
        DB_in = d;
        tick();
        chk("wr_dreq_drop", dreq_on(), 0);
        chk("wr_oe", DB_oe, 0);
        IOW_N = 1'b1;
        tick();
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else                     m_ovr = 1'b1;
        if (eop) m_done = 1'b1;
        chk("wr_dreq", dreq_on(), exp_dreq());
        DACK  = dack_level(0);
        EOP_N = 1'b1;
        DB_in = 8'($urandom);
        tick();
    endtask

    task automatic pop_rx();
        chk("snk_valid", snk_valid, rx_q.size() > 0);
        if (rx_q.size() > 0) chk("snk_data", snk_data, rx_q[0]);
        snk_ready = 1'b1;
        tick();
        snk_ready = 1'b0;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    initial begin
        RESET_N = 1'b0; DACK = dack_level(0); IOR_N = 1'b1; IOW_N = 1'b1;
        EOP_N = 1'b1; DB_in = '0; dir = 1'b0; start = 1'b0;
        src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
        m_armed = 0; m_done = 0; m_ovr = 0; m_und = 0; m_dir = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_dreq", dreq_on(), 0);
        chk("rst_oe", DB_oe, 0);
        chk("rst_dbout", DB_out, 8'h00);
        chk("rst_src_ready", src_ready, 1);
        chk("rst_snk_valid", snk_valid, 0);
        chk_flags("rst");
        RESET_N = 1'b1;
        tick();

        // Single byte dev->mem
        push_tx(8'hA5);
        do_start();
        chk("t1_dreq", dreq_on(), 1);
        bus_read(0);
        chk("t1_dreq_empty", dreq_on(), 0);

        // Three queued bytes in single mode
        for (int i = 0; i < 3; i++) push_tx(8'($urandom));
        for (int i = 0; i < 3; i++) bus_read(0);
        chk("t2_empty_dreq", dreq_on(), 0);

        // Underrun on empty TX, then one byte to show pointers did not move
        bus_read(0);
        chk_flags("t5");
        push_tx(8'h3C);

        // Strobe without DACK is ignored
        IOR_N = 1'b0;
        tick();
        chk("nodack_oe", DB_oe, 0);
        IOR_N = 1'b1;
        tick();

        // DACK withdrawn before the strobe ends: no transfer
        DACK = dack_level(1); IOR_N = 1'b0;
        tick();
        chk("abort_oe", DB_oe, 1);
        DACK = dack_level(0);
        tick();
        chk("abort_oe_off", DB_oe, 0);
        IOR_N = 1'b1;
        tick();
        chk("abort_dreq", dreq_on(), exp_dreq());
        bus_read(0);

        // Randomized mix; dir wiggles but must be held off while armed
        for (int n = 0; n < 40; n++) begin
            dir = 1'($urandom_range(0, 1));
            if (tx_q.size() == 0 || (tx_q.size() < DEPTH && $urandom_range(0, 1) == 1))
                push_tx(8'($urandom));
            else
                bus_read(0);
        end
        dir = 1'b0;
        while (tx_q.size() > 0) bus_read(0);

        // EOP on the 2nd of 4 transfers
        for (int i = 0; i < 4; i++) push_tx(8'($urandom));
        bus_read(0);
        bus_read(1);
        chk_flags("t4");
        chk("t4_dreq", dreq_on(), 0);
        do_start();
        chk("t4_restart_done", done, 0);
        chk("t4_restart_dreq", dreq_on(), 1);
        bus_read(0);
        bus_read(1);
        chk_flags("t4b");

        // mem->dev fill to overrun
        dir = 1'b1;
        tick();
        do_start();
        chk("t3_dreq", dreq_on(), 1);
        for (int i = 0; i < DEPTH + 1; i++) bus_write(8'($urandom), 0);
        chk_flags("t3");
        for (int i = 0; i < DEPTH; i++) pop_rx();
        chk("t3_rx_empty", snk_valid, 0);
        chk("t3_dreq_again", dreq_on(), 1);

        // Async reset while driving the bus
        bus_write(8'($urandom), 1);
        chk_flags("t6pre");
        dir = 1'b0;
        push_tx(8'h5A);
        do_start();
        chk("t6_dreq", dreq_on(), 1);
        DACK = dack_level(1); IOR_N = 1'b0;
        tick();
        chk("t6_oe", DB_oe, 1);
        chk("t6_data", DB_out, 8'h5A);
        #2 RESET_N = 1'b0;
        #1;
        tx_q.delete(); rx_q.delete();
        m_armed = 0; m_done = 0; m_ovr = 0; m_und = 0;
        chk("t6_oe_async", DB_oe, 0);
        chk("t6_dbout_async", DB_out, 8'h00);
        chk("t6_dreq_async", dreq_on(), 0);
        chk("t6_snk_valid", snk_valid, 0);
        chk("t6_src_ready", src_ready, 1);
        chk_flags("t6");
        DACK = dack_level(0); IOR_N = 1'b1;
        tick();
        RESET_N = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
